// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON state type, round constants and engine encodings
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [3:0] NUM_ROUNDS = 4'd12;

    typedef enum logic [1:0] {
        NR_P12  = 2'b00,
        NR_P8   = 2'b01,
        NR_P6   = 2'b10,
        NR_RSVD = 2'b11
    } nr_e;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] rc(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    // Permutations always finish at round index 12; shorter ones start later.
    function automatic logic [3:0] first_round(input logic [1:0] nr);
        case (nr)
            NR_P8:   return 4'd4;
            NR_P6:   return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// rtl/ascon_perm_engine_if.sv - mode-FSM to permutation-engine control and data bundle
interface ascon_perm_engine_if #(
    parameter int RATE_WORDS = 1
);
    import ascon_pack::*;

    logic                     start_i;
    logic [1:0]               nr_i;
    logic                     load_i;
    type_state                state_i;
    logic                     xor_in_en_i;
    logic [RATE_WORDS*64-1:0] data_in_i;
    logic                     xor_out_en_i;
    logic [255:0]             data_out_i;
    type_state                state_o;
    logic [RATE_WORDS*64-1:0] rate_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, nr_i, load_i, state_i, xor_in_en_i, data_in_i, xor_out_en_i, data_out_i,
        input  state_o, rate_o, busy_o, done_o
    );

    modport slave (
        input  start_i, nr_i, load_i, state_i, xor_in_en_i, data_in_i, xor_out_en_i, data_out_i,
        output state_o, rate_o, busy_o, done_o
    );

endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one full ASCON round for a given round index
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state after_const;
    type_state after_sub;

    constant_addition u_const (
        .state_i (state_i),
        .round_i (round_i),
        .state_o (after_const)
    );

    substitution_layer u_sub (
        .state_i (after_const),
        .state_o (after_sub)
    );

    diffusion_layer u_diff (
        .state_i (after_sub),
        .state_o (state_o)
    );

endmodule

// File: rtl/constant_addition.sv
// rtl/constant_addition.sv - XOR the round constant into word S[2]
module constant_addition
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    always_comb begin
        state_o    = state_i;
        state_o[2] = state_i[2] ^ {56'd0, rc(round_i)};
    end

endmodule

// File: rtl/diffusion_layer.sv
// rtl/diffusion_layer.sv - per-word linear diffusion with fixed rotation pairs
module diffusion_layer
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
    assign state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
    assign state_o[2] = state_i[2] ^ ror(state_i[2],  1) ^ ror(state_i[2],  6);
    assign state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
    assign state_o[4] = state_i[4] ^ ror(state_i[4],  7) ^ ror(state_i[4], 41);

endmodule

// File: rtl/substitution_layer.sv
// rtl/substitution_layer.sv - bitsliced 5-bit ASCON S-box across all 64 columns
module substitution_layer
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);

    type_state a;
    type_state b;

    always_comb begin
        a    = state_i;
        a[0] = state_i[0] ^ state_i[4];
        a[4] = state_i[4] ^ state_i[3];
        a[2] = state_i[2] ^ state_i[1];
        // Chi step: each word picks up the AND of its two neighbours.
        for (int i = 0; i < 5; i++) begin
            b[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
        end
        state_o[0] = b[0] ^ b[4];
        state_o[1] = b[1] ^ b[0];
        state_o[2] = ~b[2];
        state_o[3] = b[3] ^ b[2];
        state_o[4] = b[4];
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - self-sequencing ASCON p12/p8/p6 engine with absorb and capacity xor
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int UNROLL     = 1,
    parameter int RATE_WORDS = 1
) (
    input logic                clock_i,
    input logic                reset_i,
    ascon_perm_engine_if.slave bus
);

    localparam int         RW      = RATE_WORDS * 64;
    localparam logic [0:0] ST_IDLE = FSM_IDLE;
    localparam logic [0:0] ST_RUN  = FSM_RUN;
    localparam logic [3:0] STEP    = 4'(UNROLL);

    logic [0:0]    fsm_q;
    type_state     state_q;
    type_state     src;
    type_state     absorbed;
    type_state     finished;
    type_state     chain [UNROLL+1];
    logic [RW-1:0] rate_q;
    logic [RW-1:0] rate_d;
    logic [3:0]    round_q;
    logic          done_q;
    logic          last_step;

    // The most significant data word lands in S[0].
    always_comb begin
        src      = bus.load_i ? bus.state_i : state_q;
        absorbed = src;
        rate_d   = '0;
        for (int w = 0; w < RATE_WORDS; w++) begin
            if (bus.xor_in_en_i) begin
                absorbed[w] = src[w] ^ bus.data_in_i[RW-1-64*w -: 64];
            end
            rate_d[RW-1-64*w -: 64] = absorbed[w];
        end
    end

    assign chain[0] = state_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        ascon_round u_round (
            .state_i (chain[u]),
            .round_i (round_q + 4'(u)),
            .state_o (chain[u+1])
        );
    end

    assign last_step = (round_q + STEP) == NUM_ROUNDS;

    always_comb begin
        finished = chain[UNROLL];
        if (last_step && bus.xor_out_en_i) begin
            for (int w = 1; w < 5; w++) begin
                finished[w] = chain[UNROLL][w] ^ bus.data_out_i[319-64*w -: 64];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rate_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fsm_q == ST_IDLE) begin
                if (bus.start_i) begin
                    state_q <= absorbed;
                    rate_q  <= rate_d;
                    round_q <= first_round(bus.nr_i);
                    fsm_q   <= ST_RUN;
                end
            end else begin
                state_q <= finished;
                round_q <= round_q + STEP;
                if (last_step) begin
                    fsm_q  <= ST_IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.state_o = state_q;
    assign bus.rate_o  = rate_q;
    assign bus.busy_o  = (fsm_q == ST_RUN);
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - directed vector bench for two engine configurations
module tb_ascon_perm_engine;
    import ascon_pack::*;

    typedef struct {
        logic [1:0]   nr;
        logic         load;
        type_state    st;
        logic         xin;
        logic [127:0] din;
        logic         xout;
        logic [255:0] dout;
        int           rounds;
        int           lat;
        int           poke;
    } vec_t;

    localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [63:0]  IV    = 64'h80400c0600000000;
    localparam type_state    INIT  = {NONCE[63:0], NONCE[127:64], KEY[63:0], KEY[127:64], IV};
    localparam type_state    PAT   = {64'h0f1e2d3c4b5a6978, 64'hdeadbeefcafef00d,
                                      64'h1122334455667788, 64'ha5a5a5a55a5a5a5a,
                                      64'h0000000100000002};
    localparam logic [255:0] DOUT  = {64'h1111111111111111, 64'h2222222222222222,
                                      64'h3333333333333333, 64'h4444444444444444};

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic      clk;
    logic      rst;
    int        total;
    int        bad;
    type_state cur [2];
    vec_t      t1 [5];
    vec_t      t2 [2];
    vec_t      z;

    ascon_perm_engine_if #(.RATE_WORDS(1)) if1 ();
    ascon_perm_engine_if #(.RATE_WORDS(2)) if2 ();

    ascon_perm_engine #(.UNROLL(1), .RATE_WORDS(1)) dut1 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (if1)
    );

    ascon_perm_engine #(.UNROLL(2), .RATE_WORDS(2)) dut2 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Reference round: table S-box applied column by column.
    function automatic type_state model_round(input type_state s, input int r);
        type_state  t;
        logic [4:0] v;
        t = s;
        t[2][7:0] = t[2][7:0] ^ 8'((15 - r) * 16 + r);
        for (int i = 0; i < 64; i++) begin
            v = {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]};
            v = SBOX[v];
            {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]} = v;
        end
        for (int k = 0; k < 5; k++) t[k] = t[k] ^ rot(t[k], ROT_A[k]) ^ rot(t[k], ROT_B[k]);
        return t;
    endfunction

    function automatic type_state model_absorb(input type_state s, input logic xin,
                                               input logic [127:0] din, input int d);
        type_state t;
        t = s;
        if (xin) begin
            if (d == 1) begin
                t[0] = t[0] ^ din[127:64];
                t[1] = t[1] ^ din[63:0];
            end else begin
                t[0] = t[0] ^ din[63:0];
            end
        end
        return t;
    endfunction

    function automatic type_state model_tail(input type_state s, input logic xout,
                                             input logic [255:0] dout);
        type_state t;
        t = s;
        if (xout) begin
            t[1] = t[1] ^ dout[255:192];
            t[2] = t[2] ^ dout[191:128];
            t[3] = t[3] ^ dout[127:64];
            t[4] = t[4] ^ dout[63:0];
        end
        return t;
    endfunction

    function automatic type_state out_state(input int d);
        return (d == 1) ? if2.state_o : if1.state_o;
    endfunction

    function automatic logic [127:0] out_rate(input int d);
        return (d == 1) ? if2.rate_o : {64'h0, if1.rate_o};
    endfunction

    function automatic int out_busy(input int d);
        return (d == 1) ? int'(if2.busy_o) : int'(if1.busy_o);
    endfunction

    function automatic int out_done(input int d);
        return (d == 1) ? int'(if2.done_o) : int'(if1.done_o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_start(input int d, input logic s);
        if (d == 1) if2.start_i = s;
        else        if1.start_i = s;
    endtask

    task automatic drive(input int d, input logic go, input vec_t v);
        if (d == 1) begin
            if2.start_i = go;           if2.nr_i = v.nr;
            if2.load_i = v.load;        if2.state_i = v.st;
            if2.xor_in_en_i = v.xin;    if2.data_in_i = v.din;
            if2.xor_out_en_i = v.xout;  if2.data_out_i = v.dout;
        end else begin
            if1.start_i = go;           if1.nr_i = v.nr;
            if1.load_i = v.load;        if1.state_i = v.st;
            if1.xor_in_en_i = v.xin;    if1.data_in_i = v.din[63:0];
            if1.xor_out_en_i = v.xout;  if1.data_out_i = v.dout;
        end
    endtask

    // Start one operation, check every intermediate state, then the done cycle.
    task automatic run_op(input string nm, input int d, input vec_t v);
        type_state m;
        type_state fin;
        vec_t      pk;
        int        u;
        int        r0;
        int        n;
        int        lat;
        u   = d + 1;
        r0  = 12 - v.rounds;
        n   = v.rounds / u;
        lat = 0;
        m = model_absorb(v.load ? v.st : cur[d], v.xin, v.din, d);
        drive(d, 1'b1, v);
        tick();
        set_start(d, 1'b0);
        check({nm, "_e0_state"}, out_state(d), m);
        check({nm, "_e0_rate"}, out_rate(d), (d == 1) ? {m[0], m[1]} : {64'h0, m[0]});
        check_int({nm, "_e0_busy"}, out_busy(d), 1);
        check_int({nm, "_e0_done"}, out_done(d), 0);
        fin = m;
        for (int r = r0; r < 12; r++) fin = model_round(fin, r);
        fin = model_tail(fin, v.xout, v.dout);
        pk = v;
        pk.nr = 2'b10; pk.load = 1'b1; pk.st = '1; pk.xin = 1'b1; pk.din = '1;
        for (int c = 1; c <= 16 && lat == 0; c++) begin
            if (c == v.poke) drive(d, 1'b1, pk);
            tick();
            set_start(d, 1'b0);
            if (out_done(d) == 1) begin
                lat = c + 1;
            end else if (c < n) begin
                for (int k = 0; k < u; k++) m = model_round(m, r0 + (c - 1) * u + k);
                check({nm, "_mid"}, out_state(d), m);
            end
        end
        check_int({nm, "_latency"}, lat, v.lat);
        check({nm, "_final"}, out_state(d), fin);
        check_int({nm, "_busy_end"}, out_busy(d), 0);
        cur[d] = fin;
    endtask

    initial begin
        logic [7:0] p6c [6];
        int         pulses;
        total = 0;
        bad   = 0;
        p6c = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        z = '{nr: 2'b00, load: 1'b0, st: '0, xin: 1'b0, din: '0, xout: 1'b0, dout: '0,
              rounds: 0, lat: 0, poke: 0};

        t1[0] = '{nr: 2'b00, load: 1'b1, st: INIT, xin: 1'b0, din: '0, xout: 1'b1,
                  dout: {128'h0, KEY}, rounds: 12, lat: 13, poke: 0};
        t1[1] = '{nr: 2'b10, load: 1'b0, st: '0, xin: 1'b1, din: {64'h0, 64'h0123456789abcdef},
                  xout: 1'b0, dout: '0, rounds: 6, lat: 7, poke: 0};
        t1[2] = '{nr: 2'b01, load: 1'b1, st: PAT, xin: 1'b1, din: {64'h0, 64'hfedcba9876543210},
                  xout: 1'b1, dout: DOUT, rounds: 8, lat: 9, poke: 3};
        t1[3] = '{nr: 2'b11, load: 1'b1, st: INIT, xin: 1'b0, din: '0, xout: 1'b0,
                  dout: '0, rounds: 12, lat: 13, poke: 5};
        t1[4] = '{nr: 2'b00, load: 1'b1, st: INIT, xin: 1'b0, din: '0, xout: 1'b0,
                  dout: '0, rounds: 12, lat: 13, poke: 0};
        t2[0] = '{nr: 2'b10, load: 1'b1, st: PAT, xin: 1'b1,
                  din: 128'h0123456789ABCDEF0123456789ABCDEF, xout: 1'b0, dout: '0,
                  rounds: 6, lat: 4, poke: 2};
        t2[1] = '{nr: 2'b00, load: 1'b0, st: '0, xin: 1'b1,
                  din: 128'hfedcba98765432100f0e0d0c0b0a0908, xout: 1'b1, dout: DOUT,
                  rounds: 12, lat: 7, poke: 0};

        drive(0, 1'b0, z);
        drive(1, 1'b0, z);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        cur[0] = '0;
        cur[1] = '0;
        check("reset_state1", if1.state_o, '0);
        check("reset_rate1", {64'h0, if1.rate_o}, '0);
        check_int("reset_busy1", if1.busy_o, 0);
        check_int("reset_done1", if1.done_o, 0);
        check("reset_state2", if2.state_o, '0);
        check_int("reset_busy2", if2.busy_o, 0);

        for (int i = 0; i < 6; i++) check_int("rc_p6", rc(4'(6 + i)), p6c[i]);
        check_int("rc_p8_first", rc(4'd4), 8'hB4);

        // Consecutive entries start on the done cycle of the previous one.
        for (int i = 0; i < 5; i++) run_op($sformatf("u1_vec%0d", i), 0, t1[i]);
        for (int i = 0; i < 2; i++) run_op($sformatf("u2_vec%0d", i), 1, t2[i]);

        drive(0, 1'b1, t1[0]);
        tick();
        set_start(0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_state", if1.state_o, '0);
        check("abort_rate", {64'h0, if1.rate_o}, '0);
        check_int("abort_busy", if1.busy_o, 0);
        check_int("abort_done", if1.done_o, 0);
        rst = 1'b0;
        cur[0] = '0;
        cur[1] = '0;
        pulses = 0;
        repeat (14) begin
            tick();
            if (if1.done_o) pulses++;
        end
        check_int("abort_no_done", pulses, 0);
        run_op("post_reset", 0, t1[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
